lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store request from EX, drives
//  rd_en/rd_addr or wr_en/wr_addr/wr_data/wr_len to data_mem, then returns an extended
//  load result or store completion to WB via valid/ready.
//  Single outstanding op; detects misaligned/illegal ops without touching memory.
// PARAMETERS
//  XLEN         64  data/address width
//  ALIGN_CHECK  1   1: misaligned access raises exception; 0: issued as-is (memory handles)
// PORTS
//  clk            in   1     clock, all state on posedge
//  rst            in   1     synchronous reset, active-high
//  req_valid      in   1     EX request valid
//  req_ready      out  1     block can accept request this cycle
//  req_we         in   1     1=store, 0=load
//  req_funct3     in   3     RISC-V funct3: 000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  req_addr       in   XLEN  byte address
//  req_wdata      in   XLEN  store data (low bytes used)
//  resp_valid     out  1     result valid to WB
//  resp_ready     in   1     WB accepts result
//  resp_data      out  XLEN  extended load data; 0 for stores/exceptions
//  resp_exc       out  1     exception flag
//  resp_exc_code  out  4     2 illegal, 4 load misaligned, 6 store misaligned
//  rd_en          out  1     to data_mem
//  rd_addr        out  XLEN  to data_mem
//  rd_data        in   XLEN  from data_mem, combinational, same cycle as rd_en
//  wr_en          out  1     to data_mem, committed at posedge
//  wr_addr        out  XLEN  to data_mem
//  wr_data        out  XLEN  to data_mem, bytes above size zeroed
//  wr_len         out  8     1/2/4/8 bytes
// BEHAVIOUR
//  - States IDLE, ACCESS, RESP. Reset (sync, dominant): state=IDLE; resp_* =0;
//    rd_en=wr_en=0; rd_addr/wr_addr/wr_data/wr_len=0; req_ready=0 while rst high.
//  - req_ready = (IDLE | (RESP & resp_ready)) & ~rst. Handshake fire = req_valid & req_ready;
//    request fields captured into registers on fire.
//  - Decode on fire: size = 1<<funct3[1:0]; illegal if funct3==111 or (req_we & funct3[2]);
//    misaligned if ALIGN_CHECK & (addr & (size-1))!=0. Illegal takes priority.
//  - Fire with exception -> RESP directly (no memory access), resp_exc=1, code as above.
//  - Fire without exception -> ACCESS (exactly 1 cycle): mem signals driven from captured regs;
//    load: rd_en=1, rd_data extended per funct3 and registered into resp_data at end of cycle;
//    store: wr_en=1, write commits at end of ACCESS cycle. -> RESP.
//  - Memory outputs are 0 outside ACCESS (no spurious DPI reads/writes).
//  - RESP: resp_valid=1, data/exc held stable until resp_ready. On resp_ready: if req_valid,
//    accept next request (-> ACCESS or RESP) same cycle; else -> IDLE, resp_valid deasserts.
//  - Latency: fire at N -> resp_valid at N+2 (N+1 for exceptions). Peak throughput 1 op/2 cycles.
//  - Extension: B/H/W sign-extend from bit 7/15/31; BU/HU/WU zero-extend; D passes 64 bits.
//  - rst during ACCESS: wr_en forced 0 that cycle, no write; op dropped, no response.
//  - rst during RESP: pending response discarded.
// STRUCTURE
//  - Package lsu_pkg: funct3 localparams, state enum, exception code constants,
//    function size_of(funct3).
//  - Sub-module lsu_load_ext: combinational (funct3, rd_data) -> extended XLEN result.
//  - Top: FSM, request capture regs, decode/exception logic, memory port drive.
// TESTING
//  - SD addr 0x80000008 data 0x1122334455667788 -> wr_en 1 cycle, wr_len=8, resp_exc=0, resp at N+2.
//  - LB addr 0x80000003, mem byte 0x80 -> resp_data=0xFFFFFFFFFFFFFF80; LBU -> 0x80.
//  - LW addr 0x80000002 (ALIGN_CHECK=1) -> rd_en never high, resp_exc=1, code 4, at N+1.
//  - SB funct3=100 -> code 2, wr_en stays 0; SH addr odd -> code 6.
//  - resp_ready low 5 cycles in RESP -> resp_data stable, req_ready=0; then back-to-back LD accepted.
//  - rst asserted in ACCESS of SW -> wr_en 0, no memory change, resp_valid 0 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit memory controller.
//   - funct3 encodings for RISC-V loads/stores
//   - controller state enum
//   - exception cause codes reported to WB
//   - size_of(): access size in bytes from funct3
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] EXC_ILLEGAL      = 4'd2;
    localparam logic [3:0] EXC_LD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_ST_MISALIGN  = 4'd6;

    // Unsigned variants share the size of their signed counterpart, so only
    // the low two bits matter.
    function automatic logic [7:0] size_of(input logic [2:0] funct3);
        return 8'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational load-data extension.
// Ports:
//   funct3   in   3     load type (B/H/W/D/BU/HU/WU)
//   rd_data  in   XLEN  raw data from data memory, addressed byte in bit 0
//   data     out  XLEN  sign- or zero-extended load result
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = rd_data;
        case (funct3)
            F3_B:    data = {{(XLEN-8){rd_data[7]}},   rd_data[7:0]};
            F3_H:    data = {{(XLEN-16){rd_data[15]}}, rd_data[15:0]};
            F3_W:    data = {{(XLEN-32){rd_data[31]}}, rd_data[31:0]};
            F3_D:    data = rd_data;
            F3_BU:   data = {{(XLEN-8){1'b0}},  rd_data[7:0]};
            F3_HU:   data = {{(XLEN-16){1'b0}}, rd_data[15:0]};
            F3_WU:   data = {{(XLEN-32){1'b0}}, rd_data[31:0]};
            default: data = rd_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: initiator side of the data-memory port. Accepts one load or
// store from EX, performs a single-cycle memory access, and returns the
// extended load result (or store completion / exception) to WB.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        EX request handshake
//   req_we, req_funct3         1=store/0=load, RISC-V access type
//   req_addr, req_wdata        byte address, store data (low bytes used)
//   resp_valid/resp_ready      WB response handshake
//   resp_data                  extended load data, 0 for stores/exceptions
//   resp_exc, resp_exc_code    exception flag and cause (2, 4, 6)
//   rd_en, rd_addr, rd_data    combinational read port of data_mem
//   wr_en, wr_addr, wr_data,
//   wr_len                     write port of data_mem, committed at posedge
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_exc,
    output logic [3:0]      resp_exc_code,
    output logic            rd_en,
    output logic [XLEN-1:0] rd_addr,
    input  logic [XLEN-1:0] rd_data,
    output logic            wr_en,
    output logic [XLEN-1:0] wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic [7:0]      wr_len
);

    state_t          state, state_nxt;
    logic            fire;
    logic [2:0]      align_mask;
    logic            req_illegal, req_misaligned, req_exc;
    logic [3:0]      req_code;

    logic            we_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] load_ext;

    // Zero every byte lane above the access size so data_mem never sees
    // stale upper bytes of the source register.
    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0]      f3,
                                                     input logic [XLEN-1:0] d);
        case (f3[1:0])
            2'b00:   return {{(XLEN-8){1'b0}},  d[7:0]};
            2'b01:   return {{(XLEN-16){1'b0}}, d[15:0]};
            2'b10:   return {{(XLEN-32){1'b0}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3  (funct3_q),
        .rd_data (rd_data),
        .data    (load_ext)
    );

    // A response slot frees up either when idle or when WB takes the
    // current response in this very cycle.
    assign req_ready  = ((state == IDLE) || ((state == RESP) && resp_ready)) && !rst;
    assign fire       = req_valid && req_ready;
    assign resp_valid = (state == RESP) && !rst;

    // Decode is done on the live request so an exception can skip ACCESS.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        req_illegal    = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        req_misaligned = ALIGN_CHECK && ((req_addr[2:0] & align_mask) != 3'b000);
        req_exc        = req_illegal || req_misaligned;
        if (req_illegal)
            req_code = EXC_ILLEGAL;
        else if (req_we)
            req_code = EXC_ST_MISALIGN;
        else
            req_code = EXC_LD_MISALIGN;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Memory port is driven only during ACCESS; reset forces it quiet even
    // mid-access so an interrupted store never commits.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_len    = 8'd0;
        case (state)
            IDLE: state_nxt = IDLE;
            ACCESS: begin
                if (we_q) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_q;
                    wr_data = store_lanes(funct3_q, wdata_q);
                    wr_len  = size_of(funct3_q);
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = addr_q;
                end
                state_nxt = RESP;
            end
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (fire)
            state_nxt = req_exc ? RESP : ACCESS;
        if (rst) begin
            state_nxt = IDLE;
            rd_en     = 1'b0;
            rd_addr   = '0;
            wr_en     = 1'b0;
            wr_addr   = '0;
            wr_data   = '0;
            wr_len    = 8'd0;
        end
    end

    // Request capture and response registers. Fire and ACCESS are mutually
    // exclusive because req_ready is low during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            addr_q        <= '0;
            wdata_q       <= '0;
            resp_data     <= '0;
            resp_exc      <= 1'b0;
            resp_exc_code <= 4'd0;
        end else begin
            if (fire) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                if (req_exc) begin
                    resp_data     <= '0;
                    resp_exc      <= 1'b1;
                    resp_exc_code <= req_code;
                end
            end
            if (state == ACCESS) begin
                resp_data     <= we_q ? '0 : load_ext;
                resp_exc      <= 1'b0;
                resp_exc_code <= 4'd0;
            end
        end
    end

endmodule
